divmod_arbiter: RTL and testbench
=================================

Name: divmod_arbiter

Overview:
- Shares one divmod unit between two requesters, e.g. two primogen-style candidate engines, or a prime engine plus a debug port.
- Each requester holds a level request with operands until it gets a one-cycle done pulse carrying remainder and error.
- The arbiter grants round-robin, latches operands, sequences divmod go/delay/wait, and enforces a timeout watchdog.

Parameters:
- WIDTH_LOG, 4, log2 of the operand width; WIDTH = 1 << WIDTH_LOG.
- TIMEOUT, 64, max WAIT cycles before a forced error; must be ≥ 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous and active-low.
- req0  input  1  requester 0 request, level.
- num0  input  WIDTH  requester 0 dividend.
- den0  input  WIDTH  requester 0 divisor.
- req1  input  1  requester 1 request, level.
- num1  input  WIDTH  requester 1 dividend.
- den1  input  WIDTH  requester 1 divisor.
- done0  output  1  one-cycle completion pulse for requester 0.
- done1  output  1  one-cycle completion pulse for requester 1.
- rem  output  WIDTH  remainder of the completed op; valid while done0 or done1 is high.
- err  output  1  error of the completed op (divmod error or timeout); valid with done.
- busy  output  1  high in every state except IDLE.
- div_go  output  1  divmod start strobe.
- div_num  output  WIDTH  divmod dividend.
- div_den  output  WIDTH  divmod divisor.
- div_ready  input  1  divmod ready.
- div_error  input  1  divmod error.
- div_rem  input  WIDTH  divmod remainder.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge) forces:
  - state=IDLE, done0=done1=0, err=0, rem=0, busy=0, div_go=0, div_num=0, div_den=0;
  - last=1, so requester 0 wins the first tie;
  - watchdog=0.
- Reset mid-operation abandons the op, with no done pulse. Any div_ready arriving later while in IDLE is ignored.
- State machine (5 states), transitions:
  - IDLE: if neither req is high, stay. If exactly one req is high, grant it. If both are high, grant the requester != last. On grant:
    - latch num/den of the winner into div_num/div_den;
    - store gnt;
    - go to ISSUE.
  - ISSUE: div_go=1 for exactly this cycle, then go to DLY.
  - DLY: one wait cycle so divmod registers its inputs and updates ready. Go to WAIT and clear watchdog.
  - WAIT, checked in this order:
    - if div_error=1: err<=1, rem<=0, go to DONE;
    - else if div_ready=1: rem<=div_rem, err<=0, go to DONE;
    - else if watchdog==TIMEOUT-1: err<=1, rem<=0, go to DONE;
    - otherwise watchdog<=watchdog+1 and stay.
  - DONE: done[gnt]=1 for this cycle only, last<=gnt, go to IDLE.
- Operands are latched at grant. Requester inputs may change after ISSUE without effect.
- div_num/div_den hold their value until the next grant.
- Handshake: the requester must deassert req on the edge where it samples done. A req still high in the IDLE cycle after DONE counts as a new request.
- Latency: req sampled in IDLE at cycle t gives div_go at t+1 and WAIT at t+3. If div_ready is already high in the first WAIT cycle, done is at t+4. Throughput is one op per 5 cycles minimum.
- Fairness: two continuously held requests alternate 0,1,0,1 with no starvation.
- den=0 is passed to divmod unchanged; divmod's error returns as err=1.
- Watchdog is $clog2(TIMEOUT)+1 bits. It never wraps because it is cleared in DLY.
- rem and err keep their last value outside DONE. Consumers qualify them with done.

Test Plan:
- Single op: req0, num0=17, den0=5, divmod model ready 2 cycles after go → done0 pulses exactly once with rem=2, err=0; done1 stays 0; div_go is high exactly 1 cycle.
- Simultaneous: req0 (20/7) and req1 (9/3) rise in the same cycle after reset → requester 0 is served first (rem=6, done0), then requester 1 (rem=0, done1); busy drops in the IDLE cycle between ops.
- Fairness: both reqs held continuously over 6 ops → done sequence 0,1,0,1,0,1; div_num/den match the granted requester each time.
- Divide by zero: req1, num1=9, den1=0, model raises div_error → done1 with err=1, rem=0.
- Timeout: model never raises div_ready, TIMEOUT=8 → done0 with err=1 exactly 8 WAIT cycles after entering WAIT; the next request is served normally.
- Reset mid-WAIT: rst=0 for one cycle while in WAIT → all outputs return to reset values, no done pulse occurs, and a late div_ready pulse is ignored.

Source files
------------

// File: rtl/divmod_arbiter.sv
// Round-robin arbiter sharing one divmod unit between two requesters.
// Sequences go/delay/wait per op and forces an error if the divmod never answers.
module divmod_arbiter #(
    parameter int unsigned WIDTH_LOG = 4,
    parameter int unsigned TIMEOUT   = 64,
    localparam int unsigned WIDTH    = 1 << WIDTH_LOG
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] num0_i,
    input  logic [WIDTH-1:0] den0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] den1_i,
    output logic             done0_o,
    output logic             done1_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             div_go_o,
    output logic [WIDTH-1:0] div_num_o,
    output logic [WIDTH-1:0] div_den_o,
    input  logic             div_ready_i,
    input  logic             div_error_i,
    input  logic [WIDTH-1:0] div_rem_i
);

    localparam int unsigned WdW = $clog2(TIMEOUT) + 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StDly, StWait, StDone} state_e;

    state_e           state_q;
    logic             last_q;
    logic             gnt_q;
    logic             gnt_d;
    logic [WdW-1:0]   wd_q;
    logic             done0_q;
    logic             done1_q;
    logic [WIDTH-1:0] rem_q;
    logic             err_q;
    logic             busy_q;
    logic             div_go_q;
    logic [WIDTH-1:0] div_num_q;
    logic [WIDTH-1:0] div_den_q;

    // On a tie the requester that was not served last wins.
    assign gnt_d = (req0_i && req1_i) ? ~last_q : req1_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            wd_q      <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            div_go_q  <= 1'b0;
            div_num_q <= '0;
            div_den_q <= '0;
        end else begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            div_go_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        gnt_q     <= gnt_d;
                        div_num_q <= gnt_d ? num1_i : num0_i;
                        div_den_q <= gnt_d ? den1_i : den0_i;
                        div_go_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: state_q <= StDly;
                StDly: begin
                    wd_q    <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (div_error_i || (!div_ready_i && wd_q == WdLast)) begin
                        err_q   <= 1'b1;
                        rem_q   <= '0;
                        done0_q <= ~gnt_q;
                        done1_q <= gnt_q;
                        state_q <= StDone;
                    end else if (div_ready_i) begin
                        err_q   <= 1'b0;
                        rem_q   <= div_rem_i;
                        done0_q <= ~gnt_q;
                        done1_q <= gnt_q;
                        state_q <= StDone;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StDone: begin
                    last_q  <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done0_o   = done0_q;
    assign done1_o   = done1_q;
    assign rem_o     = rem_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign div_go_o  = div_go_q;
    assign div_num_o = div_num_q;
    assign div_den_o = div_den_q;

endmodule

// File: tb/tb_divmod_arbiter.sv
// Bench for divmod_arbiter: table-driven single ops, hand-written corner sequences,
// and randomized two-requester traffic against a round-robin reference.
module tb_divmod_arbiter;

    localparam int unsigned W = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req0_i = 1'b0, req1_i = 1'b0;
    logic [W-1:0] num0_i = '0, den0_i = '0, num1_i = '0, den1_i = '0;
    logic         done0_o, done1_o, err_o, busy_o, div_go_o;
    logic [W-1:0] rem_o, div_num_o, div_den_o;

    // Divmod responder model.
    logic         m_ready = 1'b0, m_error = 1'b0;
    logic [W-1:0] m_rem = '0, m_n = '0, m_d = '0;
    int           m_cnt = 0;
    int           m_lat = 1;
    bit           m_hang = 1'b0;
    bit           saw_ready = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    bit exp_last = 1'b1;

    always #5 clk_i = ~clk_i;

    divmod_arbiter #(.WIDTH_LOG(4), .TIMEOUT(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req0_i      (req0_i),
        .num0_i      (num0_i),
        .den0_i      (den0_i),
        .req1_i      (req1_i),
        .num1_i      (num1_i),
        .den1_i      (den1_i),
        .done0_o     (done0_o),
        .done1_o     (done1_o),
        .rem_o       (rem_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .div_go_o    (div_go_o),
        .div_num_o   (div_num_o),
        .div_den_o   (div_den_o),
        .div_ready_i (m_ready),
        .div_error_i (m_error),
        .div_rem_i   (m_rem)
    );

    // Answers m_lat cycles after go; ready lands in the first WAIT cycle when m_lat == 1.
    always @(posedge clk_i) begin
        if (div_go_o) begin
            m_ready <= 1'b0;
            m_error <= 1'b0;
            m_cnt   <= m_lat;
            m_n     <= div_num_o;
            m_d     <= div_den_o;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) begin
                if (m_d == 0) m_error <= 1'b1;
                else begin
                    m_ready <= 1'b1;
                    m_rem   <= m_n % m_d;
                end
            end
        end
    end

    always @(negedge clk_i) if (m_ready) saw_ready = 1'b1;

    typedef struct {
        bit           sel;
        logic [W-1:0] num;
        logic [W-1:0] den;
        int           lat;
        bit           hang;
        logic [W-1:0] exp_rem;
        bit           exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Steps negedges until a done pulse or the budget runs out.
    task automatic wait_done(input int budget, output bit got, output bit sel,
                             output logic [W-1:0] r, output bit e,
                             output int cyc, output int gos);
        got = 1'b0; sel = 1'b0; r = '0; e = 1'b0; cyc = 0; gos = 0;
        while (!got && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            if (div_go_o) gos++;
            if (done0_o || done1_o) begin
                got = 1'b1;
                sel = done1_o;
                r   = rem_o;
                e   = err_o;
                if (done0_o && done1_o) check("both_done", 2'b11, 2'b01);
            end
        end
        if (!got) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got, s, e;
        logic [W-1:0] r;
        int cyc, gos;
        m_lat  = v.lat;
        m_hang = v.hang;
        check($sformatf("v%0d_idle_busy", idx), busy_o, 1'b0);
        if (v.sel) begin
            num1_i = v.num; den1_i = v.den; req1_i = 1'b1;
        end else begin
            num0_i = v.num; den0_i = v.den; req0_i = 1'b1;
        end
        wait_done(40, got, s, r, e, cyc, gos);
        req0_i = 1'b0;
        req1_i = 1'b0;
        check($sformatf("v%0d_sel", idx), s, v.sel);
        check($sformatf("v%0d_rem", idx), r, v.exp_rem);
        check($sformatf("v%0d_err", idx), e, v.exp_err);
        check($sformatf("v%0d_lat", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_go_cycles", idx), gos, 1);
        exp_last = v.sel;
        @(negedge clk_i);
        check($sformatf("v%0d_pulse_end", idx), {done0_o, done1_o, busy_o}, 3'b000);
    endtask

    initial begin
        bit got, s, e, p0, p1, es;
        logic [W-1:0] r, a0, b0, a1, b1, en, ed;
        int cyc, gos, nd, ng, nb;

        vecs[0] = '{1'b0, 16'd17,    16'd5,   1, 1'b0, 16'd2,   1'b0, 4};
        vecs[1] = '{1'b1, 16'd9,     16'd0,   2, 1'b0, 16'd0,   1'b1, 5};
        vecs[2] = '{1'b0, 16'd100,   16'd7,   3, 1'b0, 16'd2,   1'b0, 6};
        vecs[3] = '{1'b0, 16'd5,     16'd9,   1, 1'b0, 16'd5,   1'b0, 4};
        vecs[4] = '{1'b0, 16'd50,    16'd3,   1, 1'b1, 16'd0,   1'b1, 11};
        vecs[5] = '{1'b1, 16'd65535, 16'd256, 1, 1'b0, 16'd255, 1'b0, 4};
        vecs[6] = '{1'b1, 16'd0,     16'd3,   2, 1'b0, 16'd0,   1'b0, 5};

        repeat (3) @(negedge clk_i);
        check("reset_outputs", {done0_o, done1_o, err_o, busy_o, div_go_o, rem_o, div_num_o,
                                div_den_o}, '0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in the middle of WAIT: no done, late ready ignored.
        m_lat = 6; m_hang = 1'b0;
        num0_i = 16'd30; den0_i = 16'd4; req0_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("midrst_in_wait", busy_o, 1'b1);
        rst_ni = 1'b0; req0_i = 1'b0;
        @(negedge clk_i);
        check("midrst_outputs", {done0_o, done1_o, err_o, busy_o, div_go_o, rem_o, div_num_o,
                                 div_den_o}, '0);
        rst_ni = 1'b1;
        saw_ready = 1'b0;
        nd = 0; ng = 0; nb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (done0_o || done1_o) nd++;
            if (div_go_o) ng++;
            if (busy_o) nb++;
        end
        check("midrst_no_done", nd, 0);
        check("midrst_no_go", ng, 0);
        check("midrst_idle", nb, 0);
        exp_last = 1'b1;

        // Simultaneous requests after reset: requester 0 first.
        m_lat = 2;
        num0_i = 16'd20; den0_i = 16'd7; num1_i = 16'd9; den1_i = 16'd3;
        req0_i = 1'b1; req1_i = 1'b1;
        wait_done(40, got, s, r, e, cyc, gos);
        req0_i = 1'b0;
        check("sim_first_sel", s, 1'b0);
        check("sim_first_rem", r, 16'd6);
        check("sim_first_num", div_num_o, 16'd20);
        @(negedge clk_i);
        check("sim_gap_busy", busy_o, 1'b0);
        wait_done(40, got, s, r, e, cyc, gos);
        req1_i = 1'b0;
        check("sim_second_sel", s, 1'b1);
        check("sim_second_rem", {e, r}, {1'b0, 16'd0});
        exp_last = 1'b1;
        @(negedge clk_i);

        // Fairness with both requests held continuously.
        num0_i = 16'd40; den0_i = 16'd6; num1_i = 16'd33; den1_i = 16'd5;
        req0_i = 1'b1; req1_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_done(40, got, s, r, e, cyc, gos);
            es = ~exp_last;
            check($sformatf("fair%0d_sel", k), s, es);
            check($sformatf("fair%0d_rem", k), r, es ? 16'd3 : 16'd4);
            check($sformatf("fair%0d_opnds", k), {div_num_o, div_den_o},
                  es ? {16'd33, 16'd5} : {16'd40, 16'd6});
            exp_last = es;
        end
        req0_i = 1'b0; req1_i = 1'b0;
        @(negedge clk_i);

        // Randomized traffic against the round-robin / arithmetic reference.
        p0 = 1'b0; p1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int k = 0; k < 30; k++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                p0 = 1'b1; a0 = 16'($urandom);
                b0 = ($urandom_range(4, 0) == 0) ? 16'd0 : 16'($urandom_range(300, 1));
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                p1 = 1'b1; a1 = 16'($urandom);
                b1 = ($urandom_range(4, 0) == 0) ? 16'd0 : 16'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom_range(20, 1));
            end
            req0_i = p0; num0_i = a0; den0_i = b0;
            req1_i = p1; num1_i = a1; den1_i = b1;
            m_lat = int'($urandom_range(5, 1));
            es = (p0 && p1) ? ~exp_last : p1;
            en = es ? a1 : a0;
            ed = es ? b1 : b0;
            wait_done(40, got, s, r, e, cyc, gos);
            check($sformatf("rnd%0d_sel", k), s, es);
            check($sformatf("rnd%0d_res", k), {e, r},
                  (ed == 0) ? {1'b1, 16'd0} : {1'b0, en % ed});
            exp_last = es;
            if (s) begin p1 = 1'b0; req1_i = 1'b0; end
            else begin p0 = 1'b0; req0_i = 1'b0; end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        repeat (8) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
